// File: rtl/ecc_scrub_reader.sv
// Hamming SEC read path: fetch a codeword, correct a single-bit error,
// hand data to the consumer, optionally scrub memory, count corrections.
//
// Ports:
//   clk, clr (async active-low reset)
//   rd_req/rd_addr      : read request (sampled only when idle)
//   scrub_en, cnt_clr   : write-back enable, counter clear
//   rd_busy             : high while not idle
//   mem_addr/mem_rd_en/mem_rdata : codeword RAM read port (1-cycle latency)
//   mem_wr_en/mem_wdata : codeword RAM write port (scrub)
//   dout/dout_valid/dout_ready   : corrected data handshake
//   err_corr/err_uncorr : status of the presented word
//   corr_cnt            : saturating corrected-word count
module ecc_scrub_reader #(
  parameter int N     = 12,
  parameter int K     = 8,
  parameter int A     = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             rd_req,
  input  logic [A-1:0]     rd_addr,
  input  logic             scrub_en,
  input  logic             cnt_clr,
  output logic             rd_busy,
  output logic [A-1:0]     mem_addr,
  output logic             mem_rd_en,
  input  logic [N-1:0]     mem_rdata,
  output logic             mem_wr_en,
  output logic [N-1:0]     mem_wdata,
  output logic [K-1:0]     dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             err_corr,
  output logic             err_uncorr,
  output logic [CNT_W-1:0] corr_cnt
);

  localparam int P = N - K;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPT,
    S_DEC,
    S_WB,
    S_OUT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [A-1:0]     r_addr;
  logic [N-1:0]     r_cw_q;
  logic [N-1:0]     r_cw_fix;
  logic [K-1:0]     r_dout;
  logic             r_err_corr;
  logic             r_err_uncorr;
  logic [CNT_W-1:0] r_cnt;

  logic [P-1:0]     w_syn;
  logic             w_syn_nz;
  logic             w_syn_in;
  logic             w_fixable;
  logic [N-1:0]     w_cw_fix;
  logic [K-1:0]     w_data;

  // Syndrome bit j covers every position whose index has bit j set.
  function automatic logic [P-1:0] f_syn(
    input logic [N-1:0] cw
  );
    logic [P-1:0] s;
    s = '0;
    for (int pos = 1; pos <= N; pos++) begin
      for (int j = 0; j < P; j++) begin
        if (pos[j]) s[j] = s[j] ^ cw[pos-1];
      end
    end
    return s;
  endfunction

  // Data bits occupy the non-power-of-two positions in ascending order.
  function automatic logic [K-1:0] f_data(
    input logic [N-1:0] cw
  );
    logic [K-1:0] d;
    int           k;
    d = '0;
    k = 0;
    for (int pos = 1; pos <= N; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (k < K) d[k] = cw[pos-1];
        k++;
      end
    end
    return d;
  endfunction

  assign w_syn     = f_syn(r_cw_q);
  assign w_syn_nz  = (w_syn != '0);
  assign w_syn_in  = (32'(w_syn) <= 32'(N));
  assign w_fixable = w_syn_nz && w_syn_in;

  // Flip the addressed bit only when the syndrome names a real position;
  // otherwise the raw word passes through untouched.
  always_comb begin
    w_cw_fix = r_cw_q;
    for (int i = 0; i < N; i++) begin
      if (w_fixable && (32'(w_syn) == 32'(i + 1))) begin
        w_cw_fix[i] = ~r_cw_q[i];
      end
    end
  end

  assign w_data = f_data(w_cw_fix);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (rd_req) w_next = S_READ;
      S_READ: w_next = S_CAPT;
      S_CAPT: w_next = S_DEC;
      S_DEC: begin
        if (w_fixable && scrub_en) begin
          w_next = S_WB;
        end else begin
          w_next = S_OUT;
        end
      end
      S_WB:   w_next = S_OUT;
      S_OUT:  if (dout_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_addr       <= '0;
      r_cw_q       <= '0;
      r_cw_fix     <= '0;
      r_dout       <= '0;
      r_err_corr   <= 1'b0;
      r_err_uncorr <= 1'b0;
    end else begin
      if (r_state == S_IDLE && rd_req) begin
        r_addr <= rd_addr;
      end
      if (r_state == S_CAPT) begin
        r_cw_q <= mem_rdata;
      end
      if (r_state == S_DEC) begin
        r_cw_fix     <= w_cw_fix;
        r_dout       <= w_data;
        r_err_corr   <= w_fixable;
        r_err_uncorr <= !w_syn_in;
      end
    end
  end

  // Clear wins over a same-cycle increment; count holds at all-ones.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (r_state == S_DEC && w_fixable) begin
      if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Strobes come straight from the state register so reset kills them
  // without waiting for a clock edge.
  assign rd_busy    = (r_state != S_IDLE);
  assign mem_rd_en  = (r_state == S_READ);
  assign mem_wr_en  = (r_state == S_WB);
  assign dout_valid = (r_state == S_OUT);
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_cw_fix;
  assign dout       = r_dout;
  assign err_corr   = r_err_corr;
  assign err_uncorr = r_err_uncorr;
  assign corr_cnt   = r_cnt;

endmodule

// File: tb/tb_ecc_scrub_reader.sv
// Directed testbench for ecc_scrub_reader.
// Main instance on a small RAM model; second instance with 2-bit counter.
module tb_ecc_scrub_reader;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        rd_req = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic        scrub_en = 1'b0;
  logic        cnt_clr = 1'b0;
  logic        rd_busy;
  logic [3:0]  mem_addr;
  logic        mem_rd_en;
  logic [11:0] mem_rdata = '0;
  logic        mem_wr_en;
  logic [11:0] mem_wdata;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic        err_corr;
  logic        err_uncorr;
  logic [15:0] corr_cnt;

  logic        rd_req2 = 1'b0;
  logic [3:0]  rd_addr2 = '0;
  logic        cnt_clr2 = 1'b0;
  logic        rd_busy2;
  logic [3:0]  mem_addr2;
  logic        mem_rd_en2;
  logic [11:0] mem_rdata2 = 12'hA07;
  logic        mem_wr_en2;
  logic [11:0] mem_wdata2;
  logic [7:0]  dout2;
  logic        dout_valid2;
  logic        err_corr2;
  logic        err_uncorr2;
  logic [1:0]  corr_cnt2;

  logic [11:0] mem [16];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_addr = '0;
  logic [11:0] pl_data = '0;
  int          wr_pulses = 0;
  int          rd_pulses = 0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ecc_scrub_reader #(.N(12), .K(8), .A(4), .CNT_W(16)) u_dut (
    .clk(clk), .clr(clr), .rd_req(rd_req), .rd_addr(rd_addr),
    .scrub_en(scrub_en), .cnt_clr(cnt_clr), .rd_busy(rd_busy),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .err_corr(err_corr), .err_uncorr(err_uncorr), .corr_cnt(corr_cnt)
  );

  ecc_scrub_reader #(.N(12), .K(8), .A(4), .CNT_W(2)) u_sat (
    .clk(clk), .clr(clr), .rd_req(rd_req2), .rd_addr(rd_addr2),
    .scrub_en(1'b0), .cnt_clr(cnt_clr2), .rd_busy(rd_busy2),
    .mem_addr(mem_addr2), .mem_rd_en(mem_rd_en2), .mem_rdata(mem_rdata2),
    .mem_wr_en(mem_wr_en2), .mem_wdata(mem_wdata2), .dout(dout2),
    .dout_valid(dout_valid2), .dout_ready(1'b1),
    .err_corr(err_corr2), .err_uncorr(err_uncorr2), .corr_cnt(corr_cnt2)
  );

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) begin
    if (mem_wr_en) wr_pulses++;
    if (mem_rd_en) rd_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic preload(input logic [3:0] a, input logic [11:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  // Leaves the bench at the negedge just after the accepting edge.
  task automatic req(input logic [3:0] a);
    rd_req = 1'b1; rd_addr = a;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tests++;
    if ({rd_busy, mem_rd_en, mem_wr_en, dout_valid, err_corr, err_uncorr}
        !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags got %b exp 000000",
               {rd_busy, mem_rd_en, mem_wr_en, dout_valid, err_corr,
                err_uncorr});
    end
    tests++;
    if ({dout, mem_addr, mem_wdata, corr_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_data got dout=%h addr=%h wd=%h cnt=%h exp 0",
               dout, mem_addr, mem_wdata, corr_cnt);
    end
    clr = 1'b1;
    tick();
    tests++;
    if (rd_busy !== 1'b0 || corr_cnt2 !== 2'd0) begin
      fails++;
      $display("FAIL reset_idle got busy=%b cnt2=%0d exp 0 0",
               rd_busy, corr_cnt2);
    end
  endtask

  task automatic test_clean();
    int w0;
    preload(4'd3, 12'hA27);
    w0 = wr_pulses;
    req(4'd3);
    tests++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 4'd3 || rd_busy !== 1'b1) begin
      fails++;
      $display("FAIL clean_read got rd=%b addr=%h busy=%b exp 1 3 1",
               mem_rd_en, mem_addr, rd_busy);
    end
    tick();
    tests++;
    if (mem_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL clean_rd_pulse got %b exp 0", mem_rd_en);
    end
    tick();
    tests++;
    if (dout_valid !== 1'b0) begin
      fails++;
      $display("FAIL clean_early_valid got %b exp 0", dout_valid);
    end
    tick();
    tests++;
    if (dout_valid !== 1'b1 || dout !== 8'hA5) begin
      fails++;
      $display("FAIL clean_dout got v=%b d=%h exp 1 a5", dout_valid, dout);
    end
    tests++;
    if (err_corr !== 1'b0 || err_uncorr !== 1'b0 || corr_cnt !== 16'd0) begin
      fails++;
      $display("FAIL clean_flags got c=%b u=%b n=%0d exp 0 0 0",
               err_corr, err_uncorr, corr_cnt);
    end
    tick();
    tests++;
    if (rd_busy !== 1'b0 || wr_pulses != w0) begin
      fails++;
      $display("FAIL clean_end got busy=%b writes=%0d exp 0 0",
               rd_busy, wr_pulses - w0);
    end
  endtask

  task automatic test_scrub();
    int w0;
    preload(4'd3, 12'hA07);
    scrub_en = 1'b1;
    w0 = wr_pulses;
    req(4'd3);
    tick();
    tick();
    tick();
    tests++;
    if (mem_wr_en !== 1'b1 || mem_wdata !== 12'hA27 || mem_addr !== 4'd3) begin
      fails++;
      $display("FAIL scrub_wb got we=%b wd=%h a=%h exp 1 a27 3",
               mem_wr_en, mem_wdata, mem_addr);
    end
    tests++;
    if (dout_valid !== 1'b0 || corr_cnt !== 16'd1) begin
      fails++;
      $display("FAIL scrub_wb_state got v=%b n=%0d exp 0 1",
               dout_valid, corr_cnt);
    end
    tick();
    tests++;
    if (dout_valid !== 1'b1 || dout !== 8'hA5 || err_corr !== 1'b1 ||
        err_uncorr !== 1'b0) begin
      fails++;
      $display("FAIL scrub_out got v=%b d=%h c=%b u=%b exp 1 a5 1 0",
               dout_valid, dout, err_corr, err_uncorr);
    end
    tests++;
    if (wr_pulses != w0 + 1 || mem[3] !== 12'hA27) begin
      fails++;
      $display("FAIL scrub_mem got writes=%0d mem=%h exp 1 a27",
               wr_pulses - w0, mem[3]);
    end
    tick();
  endtask

  task automatic test_uncorr();
    int w0;
    preload(4'd3, 12'h226);
    w0 = wr_pulses;
    req(4'd3);
    tick();
    tick();
    tick();
    tests++;
    if (dout_valid !== 1'b1 || dout !== 8'h25) begin
      fails++;
      $display("FAIL uncorr_dout got v=%b d=%h exp 1 25", dout_valid, dout);
    end
    tests++;
    if (err_uncorr !== 1'b1 || err_corr !== 1'b0 || corr_cnt !== 16'd1 ||
        wr_pulses != w0) begin
      fails++;
      $display("FAIL uncorr_flags got u=%b c=%b n=%0d w=%0d exp 1 0 1 0",
               err_uncorr, err_corr, corr_cnt, wr_pulses - w0);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int r0;
    preload(4'd5, 12'hA27);
    dout_ready = 1'b0;
    req(4'd5);
    tick();
    tick();
    r0 = rd_pulses;
    for (int i = 0; i < 10; i++) begin
      rd_req = 1'b1;
      rd_addr = 4'd7;
      tick();
      tests++;
      if (dout_valid !== 1'b1 || dout !== 8'hA5 || rd_busy !== 1'b1 ||
          mem_addr !== 4'd5) begin
        fails++;
        $display("FAIL bp_hold[%0d] got v=%b d=%h b=%b a=%h exp 1 a5 1 5",
                 i, dout_valid, dout, rd_busy, mem_addr);
      end
    end
    rd_req = 1'b0;
    dout_ready = 1'b1;
    tick();
    tests++;
    if (rd_busy !== 1'b0 || dout_valid !== 1'b0 || rd_pulses != r0) begin
      fails++;
      $display("FAIL bp_release got b=%b v=%b reads=%0d exp 0 0 0",
               rd_busy, dout_valid, rd_pulses - r0);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_n;
    for (int i = 0; i < 5; i++) begin
      exp_n = (i >= 2) ? 2'd3 : 2'(i + 1);
      rd_req2 = 1'b1;
      tick();
      rd_req2 = 1'b0;
      tick();
      tick();
      tick();
      tests++;
      if (dout_valid2 !== 1'b1 || corr_cnt2 !== exp_n) begin
        fails++;
        $display("FAIL sat_cnt[%0d] got v=%b n=%0d exp 1 %0d",
                 i, dout_valid2, corr_cnt2, exp_n);
      end
      tick();
    end
    rd_req2 = 1'b1;
    tick();
    rd_req2 = 1'b0;
    tick();
    tick();
    cnt_clr2 = 1'b1;
    tick();
    cnt_clr2 = 1'b0;
    tests++;
    if (corr_cnt2 !== 2'd0 || err_corr2 !== 1'b1) begin
      fails++;
      $display("FAIL sat_clr got n=%0d c=%b exp 0 1", corr_cnt2, err_corr2);
    end
    tick();
  endtask

  task automatic test_reset_wb();
    preload(4'd3, 12'hA07);
    scrub_en = 1'b1;
    req(4'd3);
    tick();
    tick();
    tick();
    tests++;
    if (mem_wr_en !== 1'b1) begin
      fails++;
      $display("FAIL rstwb_in_wb got we=%b exp 1", mem_wr_en);
    end
    #1 clr = 1'b0;
    #1;
    tests++;
    if (mem_wr_en !== 1'b0 || rd_busy !== 1'b0 || dout_valid !== 1'b0) begin
      fails++;
      $display("FAIL rstwb_strobe got we=%b b=%b v=%b exp 0 0 0",
               mem_wr_en, rd_busy, dout_valid);
    end
    tests++;
    if ({dout, mem_addr, mem_wdata, corr_cnt, err_corr, err_uncorr} !== '0)
    begin
      fails++;
      $display("FAIL rstwb_zero got d=%h a=%h wd=%h n=%0d exp 0",
               dout, mem_addr, mem_wdata, corr_cnt);
    end
    tick();
    clr = 1'b1;
    tick();
    tests++;
    if (mem[3] !== 12'hA07) begin
      fails++;
      $display("FAIL rstwb_nowrite got mem=%h exp a07", mem[3]);
    end
    req(4'd3);
    tick();
    tick();
    tick();
    tick();
    tests++;
    if (dout_valid !== 1'b1 || dout !== 8'hA5 || err_corr !== 1'b1 ||
        corr_cnt !== 16'd1 || mem[3] !== 12'hA27) begin
      fails++;
      $display("FAIL rstwb_after got v=%b d=%h c=%b n=%0d m=%h exp 1 a5 1 1 a27",
               dout_valid, dout, err_corr, corr_cnt, mem[3]);
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    @(negedge clk);
    test_reset();
    test_clean();
    test_scrub();
    test_uncorr();
    test_backpressure();
    test_saturation();
    test_reset_wb();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
